// File: rtl/cap_pkg.sv
// Shared types and constants for the capture word packer.
package cap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } cap_state_t;

    localparam int DROP_CNT_W = 16;

    function automatic int lanes(input int smp_w);
        return 32 / smp_w;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Show-ahead synchronous FIFO with level count and synchronous clear.
// Empty head reads as zero so the output is clean after reset or clear.
module sync_fifo_fwft #(
    parameter int W  = 32,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_wr_en,
    input  logic [W-1:0]  i_wr_data,
    input  logic          i_rd_en,
    output logic [W-1:0]  o_rd_data,
    output logic [AW:0]   o_level,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [2**AW];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = (r_level == (AW+1)'(2**AW));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign w_wr = i_wr_en && (!o_full || i_rd_en) && !i_clr;
    assign w_rd = i_rd_en && !o_empty && !i_clr;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/capture_word_packer.sv
// Packs narrow capture samples into 32-bit words for the write DMA,
// and sequences the DMA capture enable and flush/reset handshake.
module capture_word_packer
    import cap_pkg::*;
#(
    parameter int SMP_W      = 8,
    parameter int FIFO_AW    = 9,
    parameter int FLUSH_IDLE = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cap_en,
    input  logic                  cap_clear,
    input  logic                  smp_valid,
    input  logic [SMP_W-1:0]      smp_data,
    output logic [31:0]           rd_data,
    output logic                  rd_data_ready,
    input  logic                  rd_data_valid,
    output logic                  rd_capture_on,
    output logic                  rd_capture_rst,
    output logic [FIFO_AW:0]      fifo_level,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  busy_flush
);

    localparam int LANES  = lanes(SMP_W);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_W  = $clog2(FLUSH_IDLE + 1);
    localparam int LVL_W  = FIFO_AW + 1;

    cap_state_t             r_state;
    logic [CNT_W-1:0]       r_idle_cnt;
    logic                   r_cap_on;
    logic                   r_flush;
    logic [31:0]            r_pack;
    logic [LANE_W-1:0]      r_lane;
    logic                   r_wvld;
    logic [31:0]            r_wdata;
    logic                   r_rdy;
    logic [DROP_CNT_W-1:0]  r_drop;

    logic [31:0]            w_word;
    logic                   w_take;
    logic                   w_last;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_drop;
    logic [LVL_W-1:0]       w_level;

    assign rd_capture_on  = r_cap_on;
    assign rd_capture_rst = r_flush;
    assign busy_flush     = r_flush;
    assign rd_data_ready  = r_rdy;
    assign fifo_level     = w_level;
    assign drop_cnt       = r_drop;

    assign w_take = (r_state == RUN) && cap_en && smp_valid;
    assign w_last = (int'(r_lane) == LANES - 1);
    assign w_pop  = rd_data_valid && !w_empty && (r_state != FLUSH);
    assign w_drop = r_wvld && w_full && !w_pop;

    always_comb begin
        w_word = r_pack;
        w_word[int'(r_lane)*SMP_W +: SMP_W] = smp_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idle_cnt <= '0;
            r_cap_on   <= 1'b0;
            r_flush    <= 1'b0;
        end else if (cap_clear) begin
            r_state    <= FLUSH;
            r_idle_cnt <= CNT_W'(FLUSH_IDLE);
            r_cap_on   <= 1'b0;
            r_flush    <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: if (cap_en) begin
                    r_state  <= RUN;
                    r_cap_on <= 1'b1;
                end
                RUN: if (!cap_en) begin
                    r_state  <= IDLE;
                    r_cap_on <= 1'b0;
                end
                // Leave only after the DMA has gone quiet long enough.
                FLUSH: if (rd_data_valid) begin
                    r_idle_cnt <= CNT_W'(FLUSH_IDLE);
                end else if (r_idle_cnt == CNT_W'(1)) begin
                    r_state <= IDLE;
                    r_flush <= 1'b0;
                end else begin
                    r_idle_cnt <= r_idle_cnt - CNT_W'(1);
                end
                default: begin
                    r_state  <= IDLE;
                    r_cap_on <= 1'b0;
                    r_flush  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pack  <= '0;
            r_lane  <= '0;
            r_wvld  <= 1'b0;
            r_wdata <= '0;
        end else if (cap_clear) begin
            r_pack  <= '0;
            r_lane  <= '0;
            r_wvld  <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_wvld <= 1'b0;
            if (w_take) begin
                if (w_last) begin
                    r_wdata <= w_word;
                    r_wvld  <= 1'b1;
                    r_pack  <= '0;
                    r_lane  <= '0;
                end else begin
                    r_pack <= w_word;
                    r_lane <= r_lane + LANE_W'(1);
                end
            end
        end
    end

    // Ready ignores words landing this edge but honours pops at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy  <= 1'b0;
            r_drop <= '0;
        end else begin
            r_rdy <= !cap_clear && (w_level > LVL_W'(w_pop));
            if (w_drop && !cap_clear && (r_drop != '1)) begin
                r_drop <= r_drop + DROP_CNT_W'(1);
            end
        end
    end

    sync_fifo_fwft #(
        .W  (32),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (cap_clear),
        .i_wr_en   (r_wvld),
        .i_wr_data (r_wdata),
        .i_rd_en   (w_pop),
        .o_rd_data (rd_data),
        .o_level   (w_level),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

endmodule

// File: tb/tb_capture_word_packer.sv
// Directed bench for capture_word_packer: vector table plus corner sequences.
module tb_capture_word_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cap_en;
    logic        cap_clear;
    logic        smp_valid;
    logic [7:0]  smp_data;
    logic [31:0] rd_data;
    logic        rd_data_ready;
    logic        rd_data_valid;
    logic        rd_capture_on;
    logic        rd_capture_rst;
    logic [9:0]  fifo_level;
    logic [15:0] drop_cnt;
    logic        busy_flush;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    capture_word_packer #(
        .SMP_W      (8),
        .FIFO_AW    (9),
        .FLUSH_IDLE (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cap_en         (cap_en),
        .cap_clear      (cap_clear),
        .smp_valid      (smp_valid),
        .smp_data       (smp_data),
        .rd_data        (rd_data),
        .rd_data_ready  (rd_data_ready),
        .rd_data_valid  (rd_data_valid),
        .rd_capture_on  (rd_capture_on),
        .rd_capture_rst (rd_capture_rst),
        .fifo_level     (fifo_level),
        .drop_cnt       (drop_cnt),
        .busy_flush     (busy_flush)
    );

    typedef struct {
        logic        sv;
        logic [7:0]  sd;
        logic        pop;
        int          lvl;
        logic        rdy;
        logic        chk_rdy;
        logic [31:0] dat;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] d);
        smp_valid = 1'b1;
        smp_data  = d;
        tick();
        smp_valid = 1'b0;
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_level"}, 32'(fifo_level), 32'd0);
        chk({nm, "_ready"}, 32'(rd_data_ready), 32'd0);
        chk({nm, "_capon"}, 32'(rd_capture_on), 32'd0);
        chk({nm, "_caprst"}, 32'(rd_capture_rst), 32'd0);
        chk({nm, "_drop"}, 32'(drop_cnt), 32'd0);
        chk({nm, "_busy"}, 32'(busy_flush), 32'd0);
        chk({nm, "_data"}, rd_data, 32'd0);
    endtask

    initial begin
        int k;
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 0, 1'b0, 1'b1, 32'h0};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 0, 1'b0, 1'b1, 32'h0};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 0, 1'b0, 1'b1, 32'h0};
        tbl[3]  = '{1'b1, 8'h44, 1'b0, 0, 1'b0, 1'b1, 32'h0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b1, 32'h44332211};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 1'b1, 32'h44332211};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 32'h0};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 32'h0};
        tbl[8]  = '{1'b1, 8'h55, 1'b0, 0, 1'b0, 1'b1, 32'h0};
        tbl[9]  = '{1'b1, 8'h66, 1'b0, 0, 1'b0, 1'b1, 32'h0};
        tbl[10] = '{1'b1, 8'h77, 1'b0, 0, 1'b0, 1'b1, 32'h0};
        tbl[11] = '{1'b1, 8'h88, 1'b0, 0, 1'b0, 1'b1, 32'h0};
        tbl[12] = '{1'b1, 8'hA1, 1'b0, 1, 1'b0, 1'b1, 32'h88776655};
        tbl[13] = '{1'b1, 8'hA2, 1'b0, 1, 1'b1, 1'b1, 32'h88776655};
        tbl[14] = '{1'b1, 8'hA3, 1'b0, 1, 1'b1, 1'b1, 32'h88776655};
        tbl[15] = '{1'b1, 8'hA4, 1'b0, 1, 1'b1, 1'b1, 32'h88776655};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 32'hA4A3A2A1};
        tbl[17] = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 1'b1, 32'hA4A3A2A1};
        tbl[18] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 32'h0};

        rst = 1'b1;
        cap_en = 1'b0;
        cap_clear = 1'b0;
        smp_valid = 1'b0;
        smp_data = '0;
        rd_data_valid = 1'b0;
        tick();
        tick();
        chk_reset_outs("reset");
        rst = 1'b0;
        cap_en = 1'b1;
        tick();
        chk("run_capon", 32'(rd_capture_on), 32'd1);

        for (int i = 0; i < 19; i++) begin
            smp_valid = tbl[i].sv;
            smp_data = tbl[i].sd;
            rd_data_valid = tbl[i].pop;
            tick();
            chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(tbl[i].lvl));
            if (tbl[i].chk_rdy)
                chk($sformatf("vec%0d_ready", i), 32'(rd_data_ready), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d_data", i), rd_data, tbl[i].dat);
        end
        smp_valid = 1'b0;
        rd_data_valid = 1'b0;

        // Pause keeps the partial word; samples while paused are ignored.
        feed(8'h01);
        feed(8'h02);
        feed(8'h03);
        cap_en = 1'b0;
        smp_valid = 1'b1;
        smp_data = 8'hEE;
        repeat (10) tick();
        smp_valid = 1'b0;
        chk("pause_capon", 32'(rd_capture_on), 32'd0);
        cap_en = 1'b1;
        tick();
        feed(8'h04);
        tick();
        tick();
        chk("pause_level", 32'(fifo_level), 32'd1);
        chk("pause_ready", 32'(rd_data_ready), 32'd1);
        chk("pause_data", rd_data, 32'h04030201);
        repeat (5) tick();
        chk("pause_one_word", 32'(fifo_level), 32'd1);
        rd_data_valid = 1'b1;
        tick();
        rd_data_valid = 1'b0;
        chk("pause_popped", 32'(fifo_level), 32'd0);

        // Fill to capacity, then overflow by three words.
        smp_valid = 1'b1;
        for (int n = 0; n < 2048; n++) begin
            smp_data = 8'(n);
            tick();
        end
        smp_valid = 1'b0;
        tick();
        tick();
        chk("full_level", 32'(fifo_level), 32'd512);
        smp_valid = 1'b1;
        for (int n = 0; n < 12; n++) begin
            smp_data = 8'hF0 + 8'(n);
            tick();
        end
        smp_valid = 1'b0;
        tick();
        tick();
        chk("ovf_drop", 32'(drop_cnt), 32'd3);
        chk("ovf_level", 32'(fifo_level), 32'd512);
        chk("ovf_head", rd_data, 32'h03020100);

        rd_data_valid = 1'b1;
        repeat (312) tick();
        rd_data_valid = 1'b0;
        chk("drain_level", 32'(fifo_level), 32'd200);
        chk("drain_head", rd_data, 32'hE3E2E1E0);

        // Clear while the DMA pads a 256-beat burst.
        cap_clear = 1'b1;
        rd_data_valid = 1'b1;
        tick();
        cap_clear = 1'b0;
        chk("flush_level", 32'(fifo_level), 32'd0);
        chk("flush_ready", 32'(rd_data_ready), 32'd0);
        chk("flush_busy", 32'(busy_flush), 32'd1);
        chk("flush_caprst", 32'(rd_capture_rst), 32'd1);
        chk("flush_capon", 32'(rd_capture_on), 32'd0);
        repeat (255) tick();
        rd_data_valid = 1'b0;
        chk("flush_hold", 32'(rd_capture_rst), 32'd1);
        chk("flush_pad_level", 32'(fifo_level), 32'd0);
        k = 0;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (!busy_flush) begin
                k = c;
                break;
            end
        end
        chk("flush_idle_cycles", 32'(k), 32'd64);
        chk("flush_exit_caprst", 32'(rd_capture_rst), 32'd0);
        chk("flush_drop_kept", 32'(drop_cnt), 32'd3);
        tick();
        chk("flush_rerun", 32'(rd_capture_on), 32'd1);

        // Asynchronous reset mid-run with seven words and a partial word.
        smp_valid = 1'b1;
        for (int n = 0; n < 30; n++) begin
            smp_data = 8'h40 + 8'(n);
            tick();
        end
        smp_valid = 1'b0;
        tick();
        chk("prerst_level", 32'(fifo_level), 32'd7);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        feed(8'h9A);
        feed(8'hBC);
        feed(8'hDE);
        feed(8'hF0);
        tick();
        tick();
        chk("postrst_level", 32'(fifo_level), 32'd1);
        chk("postrst_data", rd_data, 32'hF0DEBC9A);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/capture_word_packer.md
Name: capture_word_packer

Overview:
- Upstream feeder for the AXI write DMA.
- Accepts a narrow sample stream from a capture front-end, packs samples little-endian into 32-bit words, and buffers them in a show-ahead FIFO.
- Presents the FIFO as the DMA's rd_data / rd_data_ready / rd_data_valid interface and drives the DMA's rd_capture_on / rd_capture_rst controls, including a safe flush handshake.

Parameters:
- SMP_W, 8: sample width; legal values 8, 16, 32. LANES = 32/SMP_W.
- FIFO_AW, 9: FIFO address width; depth 2^FIFO_AW words.
- FLUSH_IDLE, 64: consecutive pop-free cycles required to leave flush; must exceed DMA write-response latency.

Ports:
- clk  in  1  single clock for block and DMA.
- rst  in  1  asynchronous, active-high reset.
- cap_en  in  1  level; 1 = capture running, 0 = pause.
- cap_clear  in  1  pulse; discard buffered data and restart the DMA from its start address.
- smp_valid  in  1  sample strobe (no backpressure).
- smp_data  in  SMP_W  sample.
- rd_data  out  32  FIFO head word.
- rd_data_ready  out  1  FIFO non-empty and not flushing.
- rd_data_valid  in  1  pop strobe from DMA.
- rd_capture_on  out  1  to DMA.
- rd_capture_rst  out  1  to DMA.
- fifo_level  out  FIFO_AW+1  words held.
- drop_cnt  out  16  words lost to FIFO full; saturating.
- busy_flush  out  1  high in FLUSH.

Behaviour:
- Reset: state IDLE, pointers 0, lane count 0, pack register 0. Outputs: rd_data_ready=0, rd_capture_on=0, rd_capture_rst=0, fifo_level=0, drop_cnt=0, busy_flush=0, rd_data=0.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE→RUN when cap_en=1.
  - RUN→IDLE when cap_en=0.
  - Any state→FLUSH on cap_clear; cap_clear has priority over cap_en.
  - FLUSH→IDLE after FLUSH_IDLE consecutive cycles with rd_data_valid=0. Any pop reloads the counter.
- Registered outputs:
  - rd_capture_on = (state==RUN).
  - rd_capture_rst = busy_flush = (state==FLUSH).
- Packing: only in RUN with smp_valid=1.
  - Sample k goes to bits [k*SMP_W +: SMP_W].
  - On lane LANES-1 the full word is written to the FIFO on the next clock edge.
  - The lane counter wraps to 0.
  - A partial word is held across RUN→IDLE→RUN.
- Latency: a word completed at edge t is written at edge t+1, and rd_data_ready is high after edge t+2. There is no empty bypass.
- FIFO full on write: the word is discarded and drop_cnt increments, saturating at 16'hFFFF. The FIFO is not corrupted.
- Pop rules:
  - rd_data_valid=1 with level>0 and not FLUSH removes the head word. The new head appears on rd_data the next cycle.
  - A pop when empty or in FLUSH is ignored, with no pointer change. The DMA pads a burst during its own reset in exactly this way.
- Simultaneous write and pop: level is unchanged; both pointers advance.
- Entering FLUSH (cycle after cap_clear):
  - Pointers, level, lane count and pack register are zeroed.
  - Writes are blocked and rd_data_ready is forced to 0.
  - drop_cnt is retained; it clears only on rst.
- rd_capture_rst is held high throughout FLUSH. The DMA therefore sees it in IDLE after finishing any in-flight burst and returns to its first-load state.
- cap_clear during FLUSH restarts the FLUSH_IDLE counter.
- rst mid-operation: everything returns to reset values immediately (asynchronous). In-flight data is lost.

Decomposition:
- Package cap_pkg:
  - cap_state_t enum (IDLE, RUN, FLUSH).
  - LANES constant function of SMP_W.
  - DROP_CNT_W=16.
- Sub-module sync_fifo_fwft:
  - Parameterised width and address width.
  - Show-ahead read, level output, synchronous clear, full/empty flags.
  - Contains the pointer and level logic.
- Top level holds the FSM, packer, flush timer and drop counter.

Test Plan:
- SMP_W=8, RUN, samples 0x11,0x22,0x33,0x44 on consecutive cycles → one FIFO word 0x44332211. rd_data_ready rises 2 cycles after the 4th sample; fifo_level=1.
- Fill with no pops until fifo_level=512, then 3 more complete words → drop_cnt=3, fifo_level=512, head word unchanged.
- 3 samples, cap_en=0 for 10 cycles with smp_valid=1, then cap_en=1 and 1 sample → exactly one word, containing the 3 pre-pause samples plus the post-pause sample. The samples during pause are ignored.
- Pop with empty FIFO, and pop coincident with write at level 1 → no level change on the empty pop; level stays 1 and rd_data advances to the new word.
- cap_clear with level=200 and DMA model popping a 256-beat burst → fifo_level=0 next cycle and rd_data_ready=0. rd_capture_rst stays high until 64 pop-free cycles after the last padded pop, then IDLE; drop_cnt preserved.
- Assert rst mid-RUN with level=7 → all outputs at reset values in the same cycle; the first word after release begins at lane 0.
